// File: rtl/alu_instr_dispatch.sv
// -----------------------------------------------------------------------------
// alu_instr_dispatch
//
// Instruction dispatch stage sitting in front of the ALU control FSM.
// 16-bit instruction words arrive over a valid/ready handshake and are
// buffered in a small circular FIFO. The dispatch FSM pops one word per idle
// cycle and decodes it:
//   - NOP words (opCode 0) retire immediately without issuing.
//   - Illegal words are dropped with a one-cycle err_illegal pulse.
//   - Legal words are latched onto opCode/Ri/Rj, issued with a one-cycle
//     start pulse, then held until the ALU FSM answers with done.
//
// Optional build macro: DISPATCH_TIMEOUT_EN
//   When defined, a watchdog aborts a WAIT that lasts TIMEOUT cycles without
//   done and pulses err_timeout. When undefined, err_timeout is tied low and
//   WAIT lasts until done.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   instr_valid    in   upstream word valid
//   instr_data     in   [15:12] opCode, [11:6] Ri, [5:0] Rj
//   instr_ready    out  FIFO not full (transfer on valid && ready)
//   start          out  one-cycle issue pulse to the ALU FSM
//   opCode/Ri/Rj   out  decoded fields of the last issued instruction
//   done           in   completion pulse from the ALU FSM
//   busy           out  instruction in ISSUE or WAIT
//   err_illegal    out  one-cycle pulse per dropped illegal word
//   err_timeout    out  one-cycle pulse per watchdog abort
//   retired_count  out  completed instructions including NOPs (wraps)
//   fifo_count     out  current FIFO occupancy
// -----------------------------------------------------------------------------
module alu_instr_dispatch #(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_REGS   = 4,
   parameter int MAX_OPCODE = 7,
   parameter int TIMEOUT    = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          instr_valid,
   input  logic [15:0]                   instr_data,
   output logic                          instr_ready,
   output logic                          start,
   output logic [3:0]                    opCode,
   output logic [5:0]                    Ri,
   output logic [5:0]                    Rj,
   input  logic                          done,
   output logic                          busy,
   output logic                          err_illegal,
   output logic                          err_timeout,
   output logic [15:0]                   retired_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_L   = CW'(FIFO_DEPTH);
   localparam logic [4:0]    MAX_OP_L  = 5'(MAX_OPCODE);
   localparam logic [6:0]    NUM_REG_L = 7'(NUM_REGS);
   // A nonsensical configuration never accepts words rather than misbehaving.
   localparam bit            CFG_OK    = (FIFO_DEPTH >= 2) && (TIMEOUT >= 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [15:0]       fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [15:0]       retired_r;
   logic [3:0]        op_r;
   logic [5:0]        ri_r, rj_r;
   logic              start_r, busy_r, ill_r;

   logic              push_s, pop_s, latch_s, retire_s;
   logic              start_s, busy_s, ill_s;
   logic [15:0]       head_s;
   logic [3:0]        head_op_s;
   logic [5:0]        head_ri_s, head_rj_s;
   logic              head_nop_s, head_illegal_s;

`ifdef DISPATCH_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LAST_L  = TW'(TIMEOUT - 1);
   logic [TW-1:0]     wait_cnt_r;
   logic              wait_clr_s, wait_inc_s, tmo_s, tmo_r;
`endif

   assign instr_ready   = CFG_OK && (count_r != DEPTH_L);
   assign push_s        = instr_valid && instr_ready;
   assign fifo_count    = count_r;
   assign retired_count = retired_r;
   assign opCode        = op_r;
   assign Ri            = ri_r;
   assign Rj            = rj_r;
   assign start         = start_r;
   assign busy          = busy_r;
   assign err_illegal   = ill_r;
`ifdef DISPATCH_TIMEOUT_EN
   assign err_timeout   = tmo_r;
`else
   assign err_timeout   = 1'b0;
`endif

   // Head-of-FIFO decode; NOP takes precedence over the legality checks.
   always_comb begin
      head_s         = fifo_mem_r[rd_ptr_r];
      head_op_s      = head_s[15:12];
      head_ri_s      = head_s[11:6];
      head_rj_s      = head_s[5:0];
      head_nop_s     = (head_op_s == 4'd0);
      head_illegal_s = ({1'b0, head_op_s} > MAX_OP_L) ||
                       ({1'b0, head_ri_s} >= NUM_REG_L) ||
                       ({1'b0, head_rj_s} >= NUM_REG_L);
   end

   // Next-state and next-output logic; start/busy/errors are registered from here.
   always_comb begin
      state_s  = state_r;
      pop_s    = 1'b0;
      latch_s  = 1'b0;
      retire_s = 1'b0;
      start_s  = 1'b0;
      busy_s   = 1'b0;
      ill_s    = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      wait_clr_s = 1'b0;
      wait_inc_s = 1'b0;
      tmo_s      = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (count_r != {CW{1'b0}}) begin
               pop_s = 1'b1;
               if (head_nop_s) begin
                  retire_s = 1'b1;
               end else if (head_illegal_s) begin
                  ill_s = 1'b1;
               end else begin
                  latch_s = 1'b1;
                  start_s = 1'b1;
                  busy_s  = 1'b1;
                  state_s = ST_ISSUE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // done is deliberately not looked at here.
            busy_s  = 1'b1;
            state_s = ST_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
            wait_clr_s = 1'b1;
`endif
         end
         ST_WAIT: begin
            if (done) begin
               // A done coinciding with the watchdog expiry wins.
               retire_s = 1'b1;
               state_s  = ST_IDLE;
            end else begin
`ifdef DISPATCH_TIMEOUT_EN
               if (wait_cnt_r == LAST_L) begin
                  tmo_s   = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  wait_inc_s = 1'b1;
                  busy_s     = 1'b1;
               end
`else
               busy_s = 1'b1;
`endif
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, registered pulses and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         start_r   <= 1'b0;
         busy_r    <= 1'b0;
         ill_r     <= 1'b0;
         retired_r <= 16'd0;
      end else begin
         state_r <= state_s;
         start_r <= start_s;
         busy_r  <= busy_s;
         ill_r   <= ill_s;
         if (retire_s) begin
            retired_r <= retired_r + 16'd1;
         end else begin
            retired_r <= retired_r;
         end
      end
   end

   // Issued fields; held through ISSUE/WAIT and kept afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r <= 4'd0;
         ri_r <= 6'd0;
         rj_r <= 6'd0;
      end else if (latch_s) begin
         op_r <= head_op_s;
         ri_r <= head_ri_s;
         rj_r <= head_rj_s;
      end else begin
         op_r <= op_r;
         ri_r <= ri_r;
         rj_r <= rj_r;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= instr_data;
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   // Watchdog: cleared on WAIT entry, counts WAIT cycles without done.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_r <= {TW{1'b0}};
         tmo_r      <= 1'b0;
      end else begin
         tmo_r <= tmo_s;
         if (wait_clr_s) begin
            wait_cnt_r <= {TW{1'b0}};
         end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end
`endif

endmodule
